cheshire_reg_arbiter: RTL and testbench
=======================================

Name: cheshire_reg_arbiter

Overview:
- Shares the single reg-bus port in front of the reg demux (CLINT, PLIC, regs, bootrom, UART, I2C, SPI host, GPIO, serial link and VGA config) between NumMst requesters.
- Requesters include the AMO-filtered AXI-to-reg bridge, the debug module and external reg masters.
- Uses round-robin arbitration with one transaction in flight.
- A watchdog completes any target access that hangs, returning an error so that no requester deadlocks the peripheral bus.

Parameters:
NumMst, 4, number of requesting masters (2..8)
AddrWidth, 48, reg-bus address width
DataWidth, 32, reg-bus data width (wstrb width = DataWidth/8)
TimeoutCycles, 1024, cycles in BUSY before abort; 0 disables the watchdog
ErrData, 32'hBADC_AB1E, rdata returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
mst_valid_i  in  NumMst  request valid per master
mst_write_i  in  NumMst  1 = write
mst_addr_i  in  NumMst x AddrWidth  address
mst_wdata_i  in  NumMst x DataWidth  write data
mst_wstrb_i  in  NumMst x DataWidth/8  byte strobes
mst_ready_o  out  NumMst  response/completion strobe per master
mst_rdata_o  out  DataWidth  read data (shared; qualified by mst_ready_o)
mst_error_o  out  1  error (shared; qualified by mst_ready_o)
slv_valid_o  out  1  downstream request valid
slv_write_o  out  1  downstream write
slv_addr_o  out  AddrWidth  downstream address
slv_wdata_o  out  DataWidth  downstream write data
slv_wstrb_o  out  DataWidth/8  downstream strobes
slv_ready_i  in  1  downstream completion
slv_rdata_i  in  DataWidth  downstream read data
slv_error_i  in  1  downstream error
busy_o  out  1  FSM not in IDLE
grant_idx_o  out  $clog2(NumMst)  currently/last granted master
timeout_o  out  1  one-cycle pulse on watchdog abort
abandon_o  out  1  one-cycle pulse when the granted master drops valid mid-transfer

Behaviour:
Protocol
- Reg-bus protocol: a master holds valid and its payload stable until it sees ready.
- Ready means completion in that cycle; rdata and error are valid only then.

Reset (rst_i sampled high at clk_i edge)
- state = IDLE, RR pointer = 0, grant_idx_o = 0, timer = 0.
- All outputs 0: slv_valid_o, mst_ready_o, busy_o, timeout_o, abandon_o, mst_error_o; mst_rdata_o = 0.
- Reset mid-transfer drops slv_valid_o on the next cycle. No response is delivered.

FSM states: IDLE, BUSY, RESP_ERR.

IDLE
- Round-robin selection: the first master with valid=1, searching from the RR pointer upward and wrapping modulo NumMst.
- If any master is valid: register grant_idx, clear timer, go to BUSY.
- Arbitration latency is 1 cycle; no request goes downstream in IDLE.

BUSY
- slv_valid_o = 1. The slv_* payload is a combinational mux of the granted master's inputs.
- If slv_ready_i = 1:
  - mst_ready_o[grant] = 1, mst_rdata_o = slv_rdata_i, mst_error_o = slv_error_i, all in the same cycle.
  - RR pointer = (grant + 1) mod NumMst; go to IDLE.
- Else if TimeoutCycles != 0 and timer == TimeoutCycles-1:
  - Go to RESP_ERR and pulse timeout_o.
  - slv_valid_o stays 1 this cycle and is 0 from the next cycle.
- Else if mst_valid_i[grant] = 0:
  - Pulse abandon_o; slv_valid_o = 0 this cycle (the mux follows the dropped valid).
  - Go to IDLE; RR pointer advances past grant.
- Else timer++ (saturating, width $clog2(TimeoutCycles+1)).
- Priority when events coincide: slv_ready_i beats timeout, and timeout beats abandon.

RESP_ERR
- Lasts 1 cycle: mst_ready_o[grant] = 1, mst_error_o = 1, mst_rdata_o = ErrData.
- RR pointer advances; go to IDLE.
- A late slv_ready_i arriving here or in IDLE is ignored.

Static properties
- mst_ready_o is one-hot or zero.
- At most one transaction is outstanding.
- Minimum turnaround is 2 cycles per access (IDLE, then BUSY with ready).
- A continuously requesting master waits at most NumMst-1 transactions.
- busy_o = (state != IDLE). grant_idx_o holds its last value in IDLE.

Test Plan:
- Single read: master 2 read addr 0x0300_2000; slave ready on 3rd BUSY cycle with rdata 0xA5 -> slv_valid_o high 3 cycles, mst_ready_o = 4'b0100 for 1 cycle with rdata 0xA5, error 0; grant_idx_o = 2; busy_o low next cycle.
- Round-robin fairness: all 4 masters valid continuously, slave always ready -> grant order 0,1,2,3,0,1 with one completion every 2 cycles; no master served twice before others.
- Timeout: TimeoutCycles = 8, slave never ready -> slv_valid_o high exactly 8 cycles; timeout_o pulses once; next cycle mst_ready_o[grant] = 1, error = 1, rdata = 0xBADCAB1E; state returns to IDLE.
- Coincidence: slv_ready_i rises on the same cycle the timer expires -> normal completion with slave data; timeout_o stays 0.
- Abandon and late ready: master 1 drops valid on BUSY cycle 2 -> abandon_o pulse, no mst_ready_o; next grant goes to master 2 when masters 1 and 2 are valid; a stray slv_ready_i while in IDLE -> no mst_ready_o.
- Reset mid-transfer: rst_i asserted during BUSY -> next cycle all outputs 0, grant_idx_o = 0; after release, master 3 alone requests and is granted.

Source files
------------

// File: rtl/cheshire_reg_arbiter.sv
// Round-robin arbiter sharing one reg-bus port between NumMst requesters.
// Only one transaction is in flight at a time. A watchdog aborts hung
// target accesses and answers them with an error, so no requester can
// lock up the peripheral bus.
module cheshire_reg_arbiter #(
    parameter int unsigned          NumMst        = 4,
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter logic [DataWidth-1:0] ErrData       = DataWidth'(32'hBADC_AB1E)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumMst-1:0]                     mst_valid_i,
    input  logic [NumMst-1:0]                     mst_write_i,
    input  logic [NumMst-1:0][AddrWidth-1:0]      mst_addr_i,
    input  logic [NumMst-1:0][DataWidth-1:0]      mst_wdata_i,
    input  logic [NumMst-1:0][DataWidth/8-1:0]    mst_wstrb_i,
    output logic [NumMst-1:0]                     mst_ready_o,
    output logic [DataWidth-1:0]                  mst_rdata_o,
    output logic                                  mst_error_o,
    output logic                                  slv_valid_o,
    output logic                                  slv_write_o,
    output logic [AddrWidth-1:0]                  slv_addr_o,
    output logic [DataWidth-1:0]                  slv_wdata_o,
    output logic [DataWidth/8-1:0]                slv_wstrb_o,
    input  logic                                  slv_ready_i,
    input  logic [DataWidth-1:0]                  slv_rdata_i,
    input  logic                                  slv_error_i,
    output logic                                  busy_o,
    output logic [$clog2(NumMst)-1:0]             grant_idx_o,
    output logic                                  timeout_o,
    output logic                                  abandon_o
);

    localparam int unsigned IdxW  = $clog2(NumMst);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned TmrW  = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 1;

    // Timer value at which the watchdog fires; the timer itself saturates.
    localparam logic [TmrW-1:0] TmrLast = (TimeoutCycles > 32'd0) ?
                                          TmrW'(TimeoutCycles - 32'd1) : {TmrW{1'b0}};
    localparam logic [TmrW-1:0] TmrMax  = {TmrW{1'b1}};
    localparam logic            WdEn    = (TimeoutCycles != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_RESP_ERR = 2'd2
    } state_e;

    state_e            state_r,  state_s;
    logic [IdxW-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IdxW-1:0]   grant_r,  grant_s;
    logic [TmrW-1:0]   timer_r,  timer_s;

    logic                  ready_hit_s;
    logic                  slv_valid_s;
    logic [DataWidth-1:0]  rdata_s;
    logic                  error_s;
    logic                  timeout_s;
    logic                  abandon_s;
    logic                  slv_write_s;
    logic [AddrWidth-1:0]  slv_addr_s;
    logic [DataWidth-1:0]  slv_wdata_s;
    logic [StrbW-1:0]      slv_wstrb_s;

    // First valid master at or above ptr, wrapping modulo NumMst.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumMst-1:0] valid,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NumMst; i++) begin
            idx = (32'(ptr) + i) % NumMst;
            if (!found && valid[idx]) begin
                pick  = IdxW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Index following g, wrapping modulo NumMst.
    function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] g);
        return IdxW'((32'(g) + 32'd1) % NumMst);
    endfunction

    // Next-state, pointer/timer update and per-state response outputs.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        grant_s     = grant_r;
        timer_s     = timer_r;
        ready_hit_s = 1'b0;
        slv_valid_s = 1'b0;
        rdata_s     = {DataWidth{1'b0}};
        error_s     = 1'b0;
        timeout_s   = 1'b0;
        abandon_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|mst_valid_i) begin
                    grant_s = rr_pick(mst_valid_i, rr_ptr_r);
                    timer_s = {TmrW{1'b0}};
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                slv_valid_s = 1'b1;
                if (slv_ready_i) begin
                    // Completion wins over a coinciding timeout or abandon.
                    ready_hit_s = 1'b1;
                    rdata_s     = slv_rdata_i;
                    error_s     = slv_error_i;
                    rr_ptr_s    = rr_next(grant_r);
                    state_s     = ST_IDLE;
                end else if (WdEn && (timer_r == TmrLast)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_RESP_ERR;
                end else if (!mst_valid_i[grant_r]) begin
                    // Request withdrawn: the downstream valid follows it.
                    abandon_s   = 1'b1;
                    slv_valid_s = 1'b0;
                    rr_ptr_s    = rr_next(grant_r);
                    state_s     = ST_IDLE;
                end else if (timer_r != TmrMax) begin
                    timer_s = timer_r + TmrW'(1'b1);
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_RESP_ERR: begin
                ready_hit_s = 1'b1;
                error_s     = 1'b1;
                rdata_s     = ErrData;
                rr_ptr_s    = rr_next(grant_r);
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Downstream payload: granted master's request while BUSY, zero otherwise.
    always_comb begin
        slv_write_s = 1'b0;
        slv_addr_s  = {AddrWidth{1'b0}};
        slv_wdata_s = {DataWidth{1'b0}};
        slv_wstrb_s = {StrbW{1'b0}};
        if (state_r == ST_BUSY) begin
            slv_write_s = mst_write_i[grant_r];
            slv_addr_s  = mst_addr_i[grant_r];
            slv_wdata_s = mst_wdata_i[grant_r];
            slv_wstrb_s = mst_wstrb_i[grant_r];
        end else begin
            slv_write_s = 1'b0;
        end
    end

    // State, round-robin pointer, grant and watchdog timer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {IdxW{1'b0}};
            grant_r  <= {IdxW{1'b0}};
            timer_r  <= {TmrW{1'b0}};
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            grant_r  <= grant_s;
            timer_r  <= timer_s;
        end
    end

    assign mst_ready_o = ready_hit_s ? ({{(NumMst-1){1'b0}}, 1'b1} << grant_r)
                                     : {NumMst{1'b0}};
    assign mst_rdata_o = rdata_s;
    assign mst_error_o = error_s;
    assign slv_valid_o = slv_valid_s;
    assign slv_write_o = slv_write_s;
    assign slv_addr_o  = slv_addr_s;
    assign slv_wdata_o = slv_wdata_s;
    assign slv_wstrb_o = slv_wstrb_s;
    assign busy_o      = (state_r != ST_IDLE);
    assign grant_idx_o = grant_r;
    assign timeout_o   = timeout_s;
    assign abandon_o   = abandon_s;

endmodule

// File: tb/tb_cheshire_reg_arbiter.sv
// Directed bench for cheshire_reg_arbiter: single read, round-robin order,
// watchdog abort, ready/timeout coincidence, abandon, stray ready and reset.
module tb_cheshire_reg_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 32;
    localparam int unsigned TC = 8;

    logic                     clk;
    logic                     rst;
    logic [N-1:0]             mst_valid;
    logic [N-1:0]             mst_write;
    logic [N-1:0][AW-1:0]     mst_addr;
    logic [N-1:0][DW-1:0]     mst_wdata;
    logic [N-1:0][DW/8-1:0]   mst_wstrb;
    logic [N-1:0]             mst_ready;
    logic [DW-1:0]            mst_rdata;
    logic                     mst_error;
    logic                     slv_valid;
    logic                     slv_write;
    logic [AW-1:0]            slv_addr;
    logic [DW-1:0]            slv_wdata;
    logic [DW/8-1:0]          slv_wstrb;
    logic                     slv_ready;
    logic [DW-1:0]            slv_rdata;
    logic                     slv_error;
    logic                     busy;
    logic [1:0]               grant_idx;
    logic                     timeout;
    logic                     abandon;

    int n_checks = 0;
    int n_errors = 0;

    cheshire_reg_arbiter #(
        .NumMst(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TC),
        .ErrData(32'hBADC_AB1E)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mst_valid_i(mst_valid), .mst_write_i(mst_write), .mst_addr_i(mst_addr),
        .mst_wdata_i(mst_wdata), .mst_wstrb_i(mst_wstrb),
        .mst_ready_o(mst_ready), .mst_rdata_o(mst_rdata), .mst_error_o(mst_error),
        .slv_valid_o(slv_valid), .slv_write_o(slv_write), .slv_addr_o(slv_addr),
        .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
        .slv_ready_i(slv_ready), .slv_rdata_i(slv_rdata), .slv_error_i(slv_error),
        .busy_o(busy), .grant_idx_o(grant_idx), .timeout_o(timeout), .abandon_o(abandon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    logic [1:0] rr_order [6];

    initial begin
        rst       = 1'b1;
        mst_valid = 4'b0000;
        mst_write = 4'b0000;
        mst_addr  = '0;
        mst_wdata = '0;
        mst_wstrb = '0;
        slv_ready = 1'b0;
        slv_rdata = 32'h0;
        slv_error = 1'b0;
        rr_order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < N; i++) begin
            mst_addr[i]  = 48'h0300_0000 + 48'(i * 32'h100);
            mst_wdata[i] = 32'h1111_0000 + 32'(i);
            mst_wstrb[i] = 4'hF;
        end
        cyc();
        cyc();
        mid();
        check_eq("rst_busy",    64'(busy),      64'd0);
        check_eq("rst_svalid",  64'(slv_valid), 64'd0);
        check_eq("rst_ready",   64'(mst_ready), 64'd0);
        check_eq("rst_grant",   64'(grant_idx), 64'd0);
        check_eq("rst_timeout", 64'(timeout),   64'd0);
        check_eq("rst_abandon", 64'(abandon),   64'd0);
        check_eq("rst_rdata",   64'(mst_rdata), 64'd0);
        check_eq("rst_error",   64'(mst_error), 64'd0);
        cyc();
        rst = 1'b0;

        // Single read by master 2, slave answers on 3rd BUSY cycle.
        mst_addr[2]  = 48'h0300_2000;
        mst_valid    = 4'b0100;
        mid();
        check_eq("rd_idle_svalid", 64'(slv_valid), 64'd0);
        cyc();
        mid();
        check_eq("rd_b1_svalid", 64'(slv_valid), 64'd1);
        check_eq("rd_b1_grant",  64'(grant_idx), 64'd2);
        check_eq("rd_b1_addr",   64'(slv_addr),  64'h0300_2000);
        check_eq("rd_b1_write",  64'(slv_write), 64'd0);
        check_eq("rd_b1_ready",  64'(mst_ready), 64'd0);
        cyc();
        mid();
        check_eq("rd_b2_svalid", 64'(slv_valid), 64'd1);
        cyc();
        slv_ready = 1'b1;
        slv_rdata = 32'h0000_00A5;
        mid();
        check_eq("rd_b3_svalid", 64'(slv_valid), 64'd1);
        check_eq("rd_b3_ready",  64'(mst_ready), 64'b0100);
        check_eq("rd_b3_rdata",  64'(mst_rdata), 64'hA5);
        check_eq("rd_b3_error",  64'(mst_error), 64'd0);
        cyc();
        mst_valid = 4'b0000;
        slv_ready = 1'b0;
        mid();
        check_eq("rd_after_busy",  64'(busy),      64'd0);
        check_eq("rd_after_grant", 64'(grant_idx), 64'd2);
        check_eq("rd_after_ready", 64'(mst_ready), 64'd0);

        // Round-robin with all masters requesting and an always-ready slave.
        do_reset();
        mst_valid = 4'b1111;
        slv_ready = 1'b1;
        slv_rdata = 32'h0000_5555;
        for (int k = 0; k < 6; k++) begin
            mid();
            check_eq($sformatf("rr%0d_idle", k),  64'(busy),      64'd0);
            check_eq($sformatf("rr%0d_idle_rdy", k), 64'(mst_ready), 64'd0);
            cyc();
            mid();
            check_eq($sformatf("rr%0d_grant", k), 64'(grant_idx), 64'(rr_order[k]));
            check_eq($sformatf("rr%0d_ready", k), 64'(mst_ready), 64'(4'b0001 << rr_order[k]));
            cyc();
        end
        mst_valid = 4'b0000;
        slv_ready = 1'b0;

        // Watchdog: master 0 read, slave silent. Pointer is 2 here.
        mst_valid = 4'b0001;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            mid();
            check_eq($sformatf("to_b%0d_svalid", i),  64'(slv_valid), 64'd1);
            check_eq($sformatf("to_b%0d_timeout", i), 64'(timeout),   64'((i == 8) ? 1 : 0));
            check_eq($sformatf("to_b%0d_ready", i),   64'(mst_ready), 64'd0);
            cyc();
        end
        mid();
        check_eq("to_err_svalid",  64'(slv_valid), 64'd0);
        check_eq("to_err_ready",   64'(mst_ready), 64'b0001);
        check_eq("to_err_error",   64'(mst_error), 64'd1);
        check_eq("to_err_rdata",   64'(mst_rdata), 64'hBADC_AB1E);
        check_eq("to_err_timeout", 64'(timeout),   64'd0);
        check_eq("to_err_busy",    64'(busy),      64'd1);
        cyc();
        mst_valid = 4'b0000;
        mid();
        check_eq("to_idle_busy",  64'(busy),      64'd0);
        check_eq("to_idle_ready", 64'(mst_ready), 64'd0);

        // Abandon: master 1 drops valid on BUSY cycle 2. Pointer is 1 here.
        mst_valid = 4'b0010;
        cyc();
        mid();
        check_eq("ab_b1_grant",  64'(grant_idx), 64'd1);
        check_eq("ab_b1_svalid", 64'(slv_valid), 64'd1);
        cyc();
        mst_valid = 4'b0000;
        mid();
        check_eq("ab_b2_abandon", 64'(abandon),   64'd1);
        check_eq("ab_b2_svalid",  64'(slv_valid), 64'd0);
        check_eq("ab_b2_ready",   64'(mst_ready), 64'd0);
        cyc();
        // Stray slave ready in IDLE while masters 1 and 2 request.
        mst_valid = 4'b0110;
        slv_ready = 1'b1;
        slv_rdata = 32'hDEAD_0001;
        mid();
        check_eq("ab_idle_busy",    64'(busy),      64'd0);
        check_eq("ab_stray_ready",  64'(mst_ready), 64'd0);
        check_eq("ab_idle_abandon", 64'(abandon),   64'd0);
        cyc();
        mid();
        check_eq("ab_next_grant", 64'(grant_idx), 64'd2);
        check_eq("ab_next_ready", 64'(mst_ready), 64'b0100);
        check_eq("ab_next_rdata", 64'(mst_rdata), 64'hDEAD_0001);
        cyc();
        mst_valid = 4'b0000;
        slv_ready = 1'b0;

        // Coincidence: slave ready on the cycle the timer expires. Pointer is 3.
        mst_valid = 4'b0010;
        mst_write = 4'b0010;
        cyc();
        for (int i = 1; i <= 7; i++) begin
            mid();
            check_eq($sformatf("co_b%0d_timeout", i), 64'(timeout), 64'd0);
            cyc();
        end
        slv_ready = 1'b1;
        slv_rdata = 32'h1234_5678;
        slv_error = 1'b1;
        mid();
        check_eq("co_write",   64'(slv_write), 64'd1);
        check_eq("co_wdata",   64'(slv_wdata), 64'h1111_0001);
        check_eq("co_timeout", 64'(timeout),   64'd0);
        check_eq("co_ready",   64'(mst_ready), 64'b0010);
        check_eq("co_rdata",   64'(mst_rdata), 64'h1234_5678);
        check_eq("co_error",   64'(mst_error), 64'd1);
        cyc();
        mst_valid = 4'b0000;
        mst_write = 4'b0000;
        slv_ready = 1'b0;
        slv_error = 1'b0;
        mid();
        check_eq("co_after_ready", 64'(mst_ready), 64'd0);
        check_eq("co_after_busy",  64'(busy),      64'd0);

        // Reset mid-transfer while master 2 is granted. Pointer is 2.
        mst_valid = 4'b0100;
        cyc();
        mid();
        check_eq("rm_busy_grant", 64'(grant_idx), 64'd2);
        check_eq("rm_busy_svld",  64'(slv_valid), 64'd1);
        cyc();
        rst       = 1'b1;
        slv_ready = 1'b1;
        cyc();
        mid();
        check_eq("rm_rst_svalid", 64'(slv_valid), 64'd0);
        check_eq("rm_rst_ready",  64'(mst_ready), 64'd0);
        check_eq("rm_rst_busy",   64'(busy),      64'd0);
        check_eq("rm_rst_grant",  64'(grant_idx), 64'd0);
        check_eq("rm_rst_rdata",  64'(mst_rdata), 64'd0);
        cyc();
        rst       = 1'b0;
        slv_ready = 1'b0;
        mst_valid = 4'b1000;
        mid();
        check_eq("rm_idle_busy", 64'(busy), 64'd0);
        cyc();
        mid();
        check_eq("rm_m3_grant",  64'(grant_idx), 64'd3);
        check_eq("rm_m3_svalid", 64'(slv_valid), 64'd1);
        check_eq("rm_m3_addr",   64'(slv_addr),  64'h0300_0300);
        cyc();
        slv_ready = 1'b1;
        mid();
        check_eq("rm_m3_ready", 64'(mst_ready), 64'b1000);
        cyc();
        mst_valid = 4'b0000;
        slv_ready = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
